// File: rtl/poyov_uart_pkg.sv
// poyov_uart_pkg: shared constants and types for the poyov UART transmitter.
//   - register offsets inside the 8-byte window
//   - STATUS field positions and a packing helper
//   - transmitter FSM state type
//   - 8N1 frame constants
package poyov_uart_pkg;

   // Register offsets. Only bit 2 of the byte address selects between them.
   localparam logic [2:0] TXDATA_OFS = 3'h0;
   localparam logic [2:0] STATUS_OFS = 3'h4;

   // STATUS layout
   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_BUSY   = 2;
   localparam int ST_OVF    = 3;
   localparam int ST_CNT_LO = 4;
   localparam int ST_CNT_W  = 5;   // bits [8:4], holds 0..16

   // 8N1 frame
   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   function automatic logic [31:0] pack_status(input logic                full,
                                               input logic                empty,
                                               input logic                busy,
                                               input logic                ovf,
                                               input logic [ST_CNT_W-1:0] cnt);
      logic [31:0] s;
      s                          = '0;
      s[ST_FULL]                 = full;
      s[ST_EMPTY]                = empty;
      s[ST_BUSY]                 = busy;
      s[ST_OVF]                  = ovf;
      s[ST_CNT_LO +: ST_CNT_W]   = cnt;
      return s;
   endfunction

endpackage

// File: rtl/poyov_uart_if.sv
// poyov_uart_if: CPU data-memory bus as seen by a memory-mapped peripheral.
//   dmem_we    store strobe
//   dmem_re    load strobe
//   dmem_addr  byte address
//   dmem_wdata store data
//   dmem_rdata load data, returned one cycle after dmem_re
// master = CPU side, slave = peripheral side.
interface poyov_uart_if;
   logic        dmem_we;
   logic        dmem_re;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;

   modport master (output dmem_we, output dmem_re, output dmem_addr,
                   output dmem_wdata, input dmem_rdata);
   modport slave  (input dmem_we, input dmem_re, input dmem_addr,
                   input dmem_wdata, output dmem_rdata);
endinterface

// File: rtl/poyov_sync_fifo.sv
// poyov_sync_fifo: single-clock FIFO, DEPTH a power of two.
//   clk, rst   clock, asynchronous active-high reset
//   push_i     write wdata_i; accepted when not full or when popping in the same cycle
//   pop_i      consume rdata_o; ignored when empty
//   rdata_o    head entry (combinational from the read pointer)
//   full_o     registered, count == DEPTH
//   empty_o    registered, count == 0
//   count_o    occupancy 0..DEPTH
module poyov_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && !empty_q;
   // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CW'(1);
      else if (do_pop && !do_push)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;

endmodule

// File: rtl/poyov_uart_tx.sv
// poyov_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
//   clk, rst  clock, asynchronous active-high reset
//   bus       CPU data bus (slave): +0 TXDATA (write pushes byte), +4 STATUS
//             (read: full/empty/busy/overflow/count, write clears overflow)
//   uart_tx   serial output, idle high, registered
//   tx_full   FIFO full, registered
module poyov_uart_tx
   import poyov_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h2000_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic         clk,
   input  logic         rst,
   poyov_uart_if.slave  bus,
   output logic         uart_tx,
   output logic         tx_full
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // ---------------- decode ----------------
   logic hit, wr_tx, wr_st, rd_st;
   assign hit   = (bus.dmem_addr[31:3] == BASE_ADDR[31:3]);
   assign wr_tx = bus.dmem_we && hit && (bus.dmem_addr[2] == TXDATA_OFS[2]);
   assign wr_st = bus.dmem_we && hit && (bus.dmem_addr[2] == STATUS_OFS[2]);
   assign rd_st = hit && (bus.dmem_addr[2] == STATUS_OFS[2]);

   // Byte-lane bits and upper store data are don't-care for this block.
   logic unused_bits;
   assign unused_bits = ^{bus.dmem_addr[1:0], bus.dmem_wdata[31:8]};

   // ---------------- FIFO ----------------
   logic          pop;
   logic [7:0]    fifo_rdata;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   poyov_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_tx),
      .pop_i   (pop),
      .wdata_i (bus.dmem_wdata[7:0]),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---------------- transmitter FSM ----------------
   tx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          baud_last;

   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;

      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            // Uses the registered empty flag, so a byte pushed into an empty
            // FIFO is popped one cycle later.
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_rdata;
               state_d = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'(DATA_BITS - 1))
                  state_d = STOP;
               else
                  bit_d = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_d = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_rdata;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered so the registered output
      // lines up with the state register.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // ---------------- status / overflow / load data ----------------
   logic        ovf_q, ovf_d;
   logic [31:0] status;
   logic [31:0] rdata_q, rdata_d;

   always_comb begin
      ovf_d = ovf_q;
      if (wr_st)
         ovf_d = 1'b0;
      else if (wr_tx && fifo_full && !pop)
         ovf_d = 1'b1;
   end

   assign status = pack_status(fifo_full, fifo_empty, (state_q != IDLE), ovf_q,
                               ST_CNT_W'(fifo_count));

   always_comb begin
      rdata_d = rdata_q;
      if (bus.dmem_re)
         rdata_d = rd_st ? status : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.dmem_rdata = rdata_q;
   assign uart_tx        = tx_q;
   assign tx_full        = fifo_full;

endmodule

// File: tb/tb_poyov_uart_tx.sv
// Bench for poyov_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_poyov_uart_tx;
   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam int          C     = 4;
   localparam int          D     = 4;
   localparam logic [31:0] A_TX  = BASE;
   localparam logic [31:0] A_ST  = BASE + 32'd4;
   localparam logic [31:0] A_OUT = BASE + 32'd8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_tx, tx_full;
   int   n_chk = 0;
   int   n_err = 0;
   logic [7:0]  rxq[$];
   logic [7:0]  q[$];
   logic [7:0]  eb[$];
   logic [7:0]  b8;
   logic [31:0] v, w;
   int          n, gap, t;

   poyov_uart_if bus ();

   poyov_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .uart_tx (uart_tx),
      .tx_full (tx_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] st(input bit full, input bit empty, input bit busy,
                                      input bit ovf, input int cnt);
      return (32'(cnt) << 4) | {28'b0, ovf, busy, empty, full};
   endfunction

   // Called on a falling edge; the store is captured at the next rising edge.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      bus.dmem_we    = 1'b1;
      bus.dmem_addr  = a;
      bus.dmem_wdata = d;
      @(negedge clk);
      bus.dmem_we    = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      bus.dmem_re   = 1'b1;
      bus.dmem_addr = a;
      @(negedge clk);
      bus.dmem_re   = 1'b0;
      d = bus.dmem_rdata;
   endtask

   // Start together with the first store: the line must stay high for the
   // cycle after the store, then carry the frames back to back.
   task automatic check_frames(input logic [7:0] b[$], input int tail);
      logic [9:0] fr;
      @(negedge clk);
      chk("tx_before_start", uart_tx, 1);
      for (int f = 0; f < b.size(); f++) begin
         fr = {1'b1, b[f], 1'b0};
         for (int k = 0; k < 10*C; k++) begin
            @(negedge clk);
            chk($sformatf("frame%0d_bit%0d_cyc%0d", f, k/C, k%C), uart_tx, fr[k/C]);
         end
      end
      for (int k = 0; k < tail; k++) begin
         @(negedge clk);
         chk("tx_idle_tail", uart_tx, 1);
      end
   endtask

   // Mid-bit sampling receiver.
   initial begin : rx_blk
      logic [7:0] rb;
      rb = '0;
      forever begin
         @(negedge clk);
         if (!rst && uart_tx === 1'b0) begin
            repeat (C/2) @(negedge clk);
            chk("rx_start_mid", uart_tx, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               rb[i] = uart_tx;
            end
            repeat (C) @(negedge clk);
            chk("rx_stop", uart_tx, 1);
            rxq.push_back(rb);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.dmem_we = 1'b0; bus.dmem_re = 1'b0;
      bus.dmem_addr = '0; bus.dmem_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // ---- reset state, quiet line ----
      chk("rst_rdata", bus.dmem_rdata, 0);
      chk("rst_tx_full", tx_full, 0);
      bus_rd(A_ST, v); chk("rst_status", v, st(0, 1, 0, 0, 0));
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         chk("idle_line", uart_tx, 1);
      end
      bus_rd(A_ST, v); chk("idle_status", v, 32'h2);

      // ---- single byte, upper store bits ignored ----
      q = {8'hA5};
      fork
         bus_wr(A_TX, 32'hDEAD_BEA5);
         check_frames(q, 0);
      join
      bus_rd(A_ST, v); chk("busy_last_stop", v, st(0, 1, 1, 0, 0));
      bus_rd(A_ST, v); chk("busy_cleared", v, 32'h2);

      // ---- five consecutive stores, back-to-back frames ----
      q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      fork
         begin
            for (int i = 0; i < 5; i++) bus_wr(A_TX, 32'(i + 1));
            bus_rd(A_ST, v); chk("five_status", v, st(1, 0, 1, 0, 4));
         end
         check_frames(q, 2*C);
      join
      bus_rd(A_ST, v); chk("five_done", v, 32'h2);

      // ---- overflow: two extra stores while full ----
      eb.delete(); q.delete();
      for (int i = 0; i < 7; i++) begin
         b8 = 8'($urandom);
         eb.push_back(b8);
         if (i < 5) q.push_back(b8);
      end
      fork
         begin
            for (int i = 0; i < 7; i++) bus_wr(A_TX, {24'($urandom), eb[i]});
            bus_rd(A_ST, v); chk("ovf_set", v, st(1, 0, 1, 1, 4));
            chk("ovf_tx_full", tx_full, 1);
            bus_wr(A_ST, 32'h0);
            bus_rd(A_ST, v); chk("ovf_cleared", v, st(1, 0, 1, 0, 4));
         end
         check_frames(q, 10*C);
      join
      bus_rd(A_ST, v); chk("ovf_done", v, 32'h2);
      chk("ovf_full_clear", tx_full, 0);

      // ---- outside the window / alias bits ----
      bus_wr(A_OUT, 32'h0000_005A);
      bus_rd(A_ST, v);  chk("win_status", v, 32'h2);
      bus_rd(A_OUT, v); chk("win_out_rd", v, 0);
      bus_rd(BASE + 32'd5, v); chk("win_alias_status", v, 32'h2);
      bus_rd(A_TX, v);  chk("txdata_rd_zero", v, 0);
      bus_rd(BASE + 32'd12, v); chk("win_out_rd2", v, 0);
      for (int k = 0; k < 12*C; k++) begin
         @(negedge clk);
         chk("win_no_frame", uart_tx, 1);
      end
      bus_rd(A_ST, v); chk("win_status_after", v, 32'h2);

      // ---- reset during data bit 3 ----
      bus_wr(A_TX, 32'hA5);
      repeat (18) @(negedge clk);
      chk("pre_rst_bit3", uart_tx, 0);
      #1 rst = 1'b1;
      #1;
      chk("rst_async_tx", uart_tx, 1);
      chk("rst_async_full", tx_full, 0);
      chk("rst_async_rdata", bus.dmem_rdata, 0);
      @(negedge clk);
      rst = 1'b0;
      bus_rd(A_ST, v); chk("post_rst_status", v, 32'h2);
      repeat (12*C) @(negedge clk);
      rxq.delete();
      b8 = 8'($urandom);
      q = {b8};
      fork
         bus_wr(A_TX, {24'h0, b8});
         check_frames(q, 2*C);
      join
      chk("rx_fresh_cnt", rxq.size(), 1);
      if (rxq.size() > 0) chk("rx_fresh_byte", rxq[0], b8);
      rxq.delete();

      // ---- randomized bursts against a byte-queue model ----
      for (int it = 0; it < 8; it++) begin
         eb.delete();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            eb.push_back(w[7:0]);
            bus_wr(A_TX, w);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               if ($urandom_range(0, 1) == 1)
                  bus_wr(A_OUT + 32'(4 * $urandom_range(0, 3)), $urandom);
               else
                  @(negedge clk);
            end
         end
         v = 32'hFFFF_FFFF;
         for (t = 0; t < 600 && v != 32'h2; t++) bus_rd(A_ST, v);
         chk($sformatf("rand%0d_idle", it), v, 32'h2);
         repeat (2) @(negedge clk);
         chk($sformatf("rand%0d_cnt", it), rxq.size(), eb.size());
         for (int i = 0; i < eb.size() && i < rxq.size(); i++)
            chk($sformatf("rand%0d_byte%0d", it, i), rxq[i], eb[i]);
         rxq.delete();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
